ctrl_decode_pipe: RTL

//  Registered, parametrised successor to the combinational write-enable/ALU decoder.

---
 rtl/ctrl_decode_pipe_pkg.sv | 38 +++
 rtl/ctrl_decode_pipe_if.sv | 30 +++
 rtl/ctrl_decode_pipe_comb.sv | 22 ++
 rtl/ctrl_decode_pipe.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared definitions for the registered opcode decoder: opcode codes, ALU
// operation encodings, FSM states and the decoded control word.
package ctrl_decode_pipe_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_COM = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [2:0] {
    ALU_ADD = OP_ADD,
    ALU_SUB = OP_SUB,
    ALU_AND = OP_AND,
    ALU_XOR = OP_XOR,
    ALU_SLL = OP_SLL,
    ALU_SRL = OP_SRL,
    ALU_COM = OP_COM,
    ALU_MUL = OP_MUL
  } aluop_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic   wen;
    aluop_e aluop;
    logic   illegal;
  } decode_t;

  localparam decode_t DECODE_RESET = '{wen: 1'b0, aluop: ALU_ADD, illegal: 1'b0};

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// Fetch-side and regfile/ALU-side handshake bundle of the decode stage.
// The stage itself uses the slave modport; its environment uses master.
interface ctrl_decode_pipe_if #(
  parameter int OPW = 4,
  parameter int RAW = 3
);

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opcode;
  logic [RAW-1:0] in_rd;
  logic           out_valid;
  logic           out_ready;
  logic           out_wen;
  logic [2:0]     out_aluop;
  logic [RAW-1:0] out_rd;
  logic           out_illegal;
  logic           busy;

  modport master (
    output in_valid, in_opcode, in_rd, out_ready,
    input  in_ready, out_valid, out_wen, out_aluop, out_rd, out_illegal, busy
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, out_ready,
    output in_ready, out_valid, out_wen, out_aluop, out_rd, out_illegal, busy
  );

endinterface

// File: rtl/ctrl_decode_pipe_comb.sv
// Pure combinational opcode -> {wen, aluop, illegal} table. Anything outside
// the eight ALU codes decodes to a harmless, flagged no-write.
module ctrl_decode_comb
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode_i,
  output decode_t        dec_o
);

  always_comb begin
    // NOTE: assign every output a default first so no path can infer a latch.
    dec_o = '{wen: 1'b0, aluop: ALU_ADD, illegal: 1'b1};
    if ((opcode_i >> 3) == '0) begin
      dec_o.wen     = 1'b1;
      dec_o.aluop   = aluop_e'(opcode_i[2:0]);
      dec_o.illegal = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered valid/ready decode stage: single-cycle for most ops, a
// configurable multi-cycle hold for MUL, with a stall-safe output register.
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int RAW     = 3,
  parameter int MUL_LAT = 3,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  ctrl_decode_pipe_if.slave   bus
);

  localparam int               CNT_W     = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               MUL_MULTI = (MUL_LAT > 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  decode_t          out_dec_q, out_dec_d;
  logic [RAW-1:0]   out_rd_q, out_rd_d;
  decode_t          hold_dec_q, hold_dec_d;
  logic [RAW-1:0]   hold_rd_q, hold_rd_d;

  decode_t raw_dec;
  decode_t in_dec;
  logic    in_ready;
  logic    busy;
  logic    slot_free;
  logic    accept;
  logic    is_mul;
  logic    mul_done;

  ctrl_decode_comb #(.OPW(OPW)) u_comb (
    .opcode_i (bus.in_opcode),
    .dec_o    (raw_dec)
  );

  // Register 0 is read-only: the write is dropped but the op still decodes.
  always_comb begin
    in_dec = raw_dec;
    if (ZERO_RO && (bus.in_rd == '0)) in_dec.wen = 1'b0;
  end

  assign slot_free = ~out_valid_q | bus.out_ready;
  assign accept    = bus.in_valid & in_ready;
  assign is_mul    = ~raw_dec.illegal & (raw_dec.aluop == ALU_MUL);
  assign mul_done  = (state_q == ST_MUL_WAIT) && (cnt_q == CNT_ONE) && slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept && is_mul && MUL_MULTI) state_d = ST_MUL_WAIT;
      ST_MUL_WAIT: if (mul_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      ST_IDLE:     in_ready = slot_free;
      ST_MUL_WAIT: busy     = 1'b1;
      default:     ;
    endcase
  end

  // A retiring output and a new result may coincide; the load wins.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_dec_d   = out_dec_q;
    out_rd_d    = out_rd_q;
    hold_dec_d  = hold_dec_q;
    hold_rd_d   = hold_rd_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (is_mul && MUL_MULTI) begin
        hold_dec_d = in_dec;
        hold_rd_d  = bus.in_rd;
        cnt_d      = CNT_LOAD;
      end else begin
        out_valid_d = 1'b1;
        out_dec_d   = in_dec;
        out_rd_d    = bus.in_rd;
      end
    end

    // The counter saturates at 1; the hold only drains into a free slot.
    if (state_q == ST_MUL_WAIT) begin
      if (cnt_q > CNT_ONE) begin
        cnt_d = cnt_q - CNT_ONE;
      end else if (slot_free) begin
        out_valid_d = 1'b1;
        out_dec_d   = hold_dec_q;
        out_rd_d    = hold_rd_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_dec_q   <= DECODE_RESET;
      out_rd_q    <= '0;
      hold_dec_q  <= DECODE_RESET;
      hold_rd_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_dec_q   <= out_dec_d;
      out_rd_q    <= out_rd_d;
      hold_dec_q  <= hold_dec_d;
      hold_rd_q   <= hold_rd_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.busy        = busy;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_wen     = out_dec_q.wen;
  assign bus.out_aluop   = out_dec_q.aluop;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_illegal = out_dec_q.illegal;

endmodule
